// File: rtl/clkout_div_bank_if.sv
// clkout_div_bank_if
//   DRP-style configuration port of clkout_div_bank.
//   daddr : register address       (master -> slave)
//   den   : access strobe, 1 cycle (master -> slave)
//   dwe   : write enable, with den (master -> slave)
//   di    : write data             (master -> slave)
//   dout  : read data, valid with drdy (slave -> master)
//   drdy  : access complete pulse  (slave -> master)
`timescale 1ns/1ps
interface clkout_div_bank_if;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] dout;
  logic        drdy;

  modport master (output daddr, den, dwe, di, input dout, drdy);
  modport slave  (input daddr, den, dwe, di, output dout, drdy);
endinterface

// File: rtl/clkout_div_bank.sv
// clkout_div_bank
//   Multi-channel clock waveform generator clocked at VCO rate. Each channel
//   has a divide (period), high time and phase delay in VCO cycles. Channels
//   restart phase-aligned; locked_o reports that all channels are running.
//   Optional macro DYN_RECONF_EN enables runtime reconfiguration through the
//   DRP port (shadow registers, applied atomically by a commit at 7'h7F).
//   Without it the DRP port is ignored and the config is fixed at DEF_*.
// Ports
//   clk_i    : VCO-rate clock (rising edge)
//   rst_ni   : asynchronous active-low reset
//   pwrdwn_i : synchronous power-down
//   drp      : DRP port (clkout_div_bank_if.slave)
//   clkout_o : channel waveforms (registered)
//   locked_o : all channels running and settled
`timescale 1ns/1ps
module clkout_div_bank #(
  parameter int unsigned NUM_CH      = 7,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEF_DIVIDE  = 2,
  parameter int unsigned DEF_HIGH    = 1,
  parameter int unsigned DEF_PHASE   = 0,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pwrdwn_i,
  clkout_div_bank_if.slave  drp,
  output logic [NUM_CH-1:0] clkout_o,
  output logic              locked_o
);

  typedef enum logic [1:0] {S_OFF, S_ALIGN, S_LOCKING, S_LOCKED} state_e;

  localparam int unsigned LC_W = $clog2(LOCK_CYCLES + 1) + 1;

  logic [CNT_W-1:0] act_div   [NUM_CH];
  logic [CNT_W-1:0] act_high  [NUM_CH];
  logic [CNT_W-1:0] act_phase [NUM_CH];
  logic             do_commit;

  // Next counter position; D=0 behaves as D=1, and >= keeps the counter in range.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] d);
    logic [CNT_W-1:0] last;
    last = (d == '0) ? '0 : d - CNT_W'(1);
    return (cnt >= last) ? '0 : cnt + CNT_W'(1);
  endfunction

`ifdef DYN_RECONF_EN
  logic [CNT_W-1:0] sh_div_q    [NUM_CH];
  logic [CNT_W-1:0] sh_high_q   [NUM_CH];
  logic [CNT_W-1:0] sh_phase_q  [NUM_CH];
  logic [CNT_W-1:0] act_div_q   [NUM_CH];
  logic [CNT_W-1:0] act_high_q  [NUM_CH];
  logic [CNT_W-1:0] act_phase_q [NUM_CH];
  logic             pend_q, we_q, drdy_q, commit_q;
  logic [6:0]       addr_q;
  logic [CNT_W-1:0] di_q;
  logic [15:0]      dout_q, rd_val;
  logic             accept;
  logic             unused_di;

  assign unused_di = ^drp.di;  // DI bits above CNT_W are don't-care
  assign accept    = drp.den && !pend_q && !drdy_q;

  // Value shown on DO in the DRDY cycle: the shadow as it is after this access.
  always_comb begin
    rd_val = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (addr_q[6:2] == 5'(c)) begin
        case (addr_q[1:0])
          2'd0:    rd_val = 16'(we_q ? di_q : sh_div_q[c]);
          2'd1:    rd_val = 16'(we_q ? di_q : sh_high_q[c]);
          2'd2:    rd_val = 16'(we_q ? di_q : sh_phase_q[c]);
          default: rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      di_q     <= '0;
      drdy_q   <= 1'b0;
      dout_q   <= '0;
      commit_q <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        sh_div_q[c]    <= CNT_W'(DEF_DIVIDE);
        sh_high_q[c]   <= CNT_W'(DEF_HIGH);
        sh_phase_q[c]  <= CNT_W'(DEF_PHASE);
        act_div_q[c]   <= CNT_W'(DEF_DIVIDE);
        act_high_q[c]  <= CNT_W'(DEF_HIGH);
        act_phase_q[c] <= CNT_W'(DEF_PHASE);
      end
    end else begin
      drdy_q   <= 1'b0;
      dout_q   <= '0;
      commit_q <= 1'b0;
      pend_q   <= accept;
      if (accept) begin
        addr_q <= drp.daddr;
        we_q   <= drp.dwe;
        di_q   <= drp.di[CNT_W-1:0];
      end
      if (pend_q) begin
        drdy_q <= 1'b1;
        dout_q <= rd_val;
        if (we_q) begin
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (addr_q[6:2] == 5'(c)) begin
              case (addr_q[1:0])
                2'd0:    sh_div_q[c]   <= di_q;
                2'd1:    sh_high_q[c]  <= di_q;
                2'd2:    sh_phase_q[c] <= di_q;
                default: ;
              endcase
            end
          end
          if (addr_q == 7'h7F && di_q[0]) begin
            commit_q <= 1'b1;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              act_div_q[c]   <= sh_div_q[c];
              act_high_q[c]  <= sh_high_q[c];
              act_phase_q[c] <= sh_phase_q[c];
            end
          end
        end
      end
    end
  end

  assign act_div   = act_div_q;
  assign act_high  = act_high_q;
  assign act_phase = act_phase_q;
  assign do_commit = commit_q;
  assign drp.dout  = dout_q;
  assign drp.drdy  = drdy_q;
`else
  logic unused_drp;

  assign unused_drp = ^{drp.daddr, drp.den, drp.dwe, drp.di};

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      act_div[c]   = CNT_W'(DEF_DIVIDE);
      act_high[c]  = CNT_W'(DEF_HIGH);
      act_phase[c] = CNT_W'(DEF_PHASE);
    end
  end

  assign do_commit = 1'b0;
  assign drp.dout  = '0;
  assign drp.drdy  = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             restart;
  logic [LC_W-1:0]  lc_q;
  logic [CNT_W-1:0] sc_q;
  logic             locked_q;
  logic [NUM_CH-1:0] run_q, clk_q, start_now;
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  always_comb begin
    start_now = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      start_now[c] = (state_q == S_ALIGN) && !run_q[c] && (sc_q == act_phase[c]);
    end
  end

  // Power-down has priority over commit; the commit still updates the active regs.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    if (pwrdwn_i) begin
      state_d = S_OFF;
    end else if (do_commit) begin
      state_d = S_ALIGN;
      restart = 1'b1;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_ALIGN;
          restart = 1'b1;
        end
        S_ALIGN:   if (&(run_q | start_now)) state_d = S_LOCKING;
        S_LOCKING: if (lc_q == LC_W'(LOCK_CYCLES)) state_d = S_LOCKED;
        default:   state_d = S_LOCKED;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_ALIGN;
      lc_q     <= '0;
      sc_q     <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= (state_d == S_LOCKED);
      lc_q     <= (state_q == S_LOCKING && state_d == S_LOCKING) ? lc_q + LC_W'(1) : '0;
      if (restart)                sc_q <= '0;
      else if (state_q == S_ALIGN) sc_q <= sc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= '0;
      clk_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (state_d == S_OFF || restart) begin
          run_q[c] <= 1'b0;
          clk_q[c] <= 1'b0;
          cnt_q[c] <= '0;
        end else if (start_now[c]) begin
          run_q[c] <= 1'b1;
          clk_q[c] <= (act_high[c] != '0);
          cnt_q[c] <= wrap_inc('0, act_div[c]);
        end else if (run_q[c]) begin
          clk_q[c] <= (cnt_q[c] < act_high[c]);
          cnt_q[c] <= wrap_inc(cnt_q[c], act_div[c]);
        end else begin
          clk_q[c] <= 1'b0;
        end
      end
    end
  end

  assign clkout_o = clk_q;
  assign locked_o = locked_q;

endmodule

// File: tb/tb_clkout_div_bank.sv
// tb_clkout_div_bank
//   Directed bench for clkout_div_bank: default run and lock latency, DRP
//   reconfiguration with phase offset, DRP timing and busy window, edge-case
//   divide/high settings, power-down, and asynchronous reset mid-lock.
//   DRP-dependent steps are built only when DYN_RECONF_EN is defined.
`timescale 1ns/1ps
module tb_clkout_div_bank;
  localparam int unsigned NCH = 7;
  localparam int unsigned LCK = 16;
`ifdef DYN_RECONF_EN
  localparam int LOCK_OFS = 20;  // ch0 phase 3 delays the lock by 3 cycles
`else
  localparam int LOCK_OFS = 17;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pwrdwn = 1'b0;
  logic [NCH-1:0] clkout;
  logic           locked;
  int             n_assert = 0;
  int             n_fail = 0;

  clkout_div_bank_if drp ();

  clkout_div_bank #(
    .NUM_CH(NCH), .CNT_W(8), .DEF_DIVIDE(2), .DEF_HIGH(1), .DEF_PHASE(0),
    .LOCK_CYCLES(LCK)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pwrdwn_i(pwrdwn), .drp(drp),
    .clkout_o(clkout), .locked_o(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Defaults D=2 H=1 P=0: all channels toggle 1,0 from the start edge.
  function automatic logic [NCH-1:0] def_vec(input int j);
    return (j % 2 == 0) ? '1 : '0;
  endfunction

`ifdef DYN_RECONF_EN
  // ch0 D=5 H=2 P=3, others default
  function automatic logic [NCH-1:0] t2_vec(input int j);
    logic [NCH-1:0] v;
    v[NCH-1:1] = (j % 2 == 0) ? '1 : '0;
    v[0] = (j >= 3) && (((j - 3) % 5) < 2);
    return v;
  endfunction

  // plus ch1 H=0, ch2 D=4 H=9, ch3 D=0 H=1
  function automatic logic [NCH-1:0] t4_vec(input int j);
    logic [NCH-1:0] v;
    v = t2_vec(j);
    v[1] = 1'b0;
    v[2] = 1'b1;
    v[3] = 1'b1;
    return v;
  endfunction
`endif

  function automatic logic [NCH-1:0] run_vec(input int j);
`ifdef DYN_RECONF_EN
    return t4_vec(j);
`else
    return def_vec(j);
`endif
  endfunction

`ifdef DYN_RECONF_EN
  // Drives one access; returns in the DRDY cycle.
  task automatic drp_xfer(input string tag, input logic [6:0] a, input logic we,
                          input logic [15:0] d, input logic [15:0] exp_do);
    drp.daddr = a;
    drp.dwe   = we;
    drp.di    = d;
    drp.den   = 1'b1;
    tick();
    drp.den = 1'b0;
    drp.dwe = 1'b0;
    check({tag, "_drdy_early"}, 32'(drp.drdy), 32'd0);
    tick();
    check({tag, "_drdy"}, 32'(drp.drdy), 32'd1);
    check({tag, "_do"}, 32'(drp.dout), 32'(exp_do));
  endtask
`endif

  initial begin
    drp.daddr = '0;
    drp.den   = 1'b0;
    drp.dwe   = 1'b0;
    drp.di    = '0;

    // 1. reset values, then default run and lock latency
    tick();
    tick();
    check("rst_clkout", 32'(clkout), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_drdy", 32'(drp.drdy), 32'd0);
    check("rst_do", 32'(drp.dout), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int j = 0; j <= 17; j++) begin
      if (j != 0) tick();
      check($sformatf("t1_clkout_%0d", j), 32'(clkout), 32'(def_vec(j)));
      check($sformatf("t1_locked_%0d", j), 32'(locked), 32'(j == 17));
    end

`ifdef DYN_RECONF_EN
    // 2. reconfigure ch0 and commit
    drp_xfer("wr_div0", 7'd0, 1'b1, 16'd5, 16'd5);
    tick();
    drp_xfer("wr_high0", 7'd1, 1'b1, 16'd2, 16'd2);
    tick();
    drp_xfer("wr_phase0", 7'd2, 1'b1, 16'd3, 16'd3);
    tick();
    drp_xfer("commit1", 7'h7F, 1'b1, 16'd1, 16'd0);
    check("commit1_locked_hold", 32'(locked), 32'd1);
    tick();
    check("commit1_locked_drop", 32'(locked), 32'd0);
    check("commit1_clkout_off", 32'(clkout), 32'd0);
    tick();
    for (int j = 0; j <= 20; j++) begin
      if (j != 0) tick();
      check($sformatf("t2_clkout_%0d", j), 32'(clkout), 32'(t2_vec(j)));
      check($sformatf("t2_locked_%0d", j), 32'(locked), 32'(j == 20));
    end

    // 3. DRP timing and busy window
    drp.daddr = 7'd0;
    drp.dwe   = 1'b0;
    drp.den   = 1'b1;
    tick();
    check("busy_drdy_early", 32'(drp.drdy), 32'd0);
    tick();
    check("busy_drdy", 32'(drp.drdy), 32'd1);
    check("busy_do_div0", 32'(drp.dout), 32'd5);
    tick();
    drp.den = 1'b0;
    check("busy_drdy_after", 32'(drp.drdy), 32'd0);
    check("busy_do_after", 32'(drp.dout), 32'd0);
    tick();
    check("busy_no_extra1", 32'(drp.drdy), 32'd0);
    tick();
    check("busy_no_extra2", 32'(drp.drdy), 32'd0);
    drp_xfer("rd_addr03", 7'h03, 1'b0, 16'd0, 16'd0);
    tick();
    drp_xfer("rd_high0", 7'd1, 1'b0, 16'd0, 16'd2);
    tick();

    // 4. edge settings
    drp_xfer("wr_high1_zero", 7'd5, 1'b1, 16'd0, 16'd0);
    tick();
    drp_xfer("wr_div2_hi_bits", 7'd8, 1'b1, 16'hFF04, 16'd4);
    tick();
    drp_xfer("wr_high2", 7'd9, 1'b1, 16'd9, 16'd9);
    tick();
    drp_xfer("wr_div3_zero", 7'd12, 1'b1, 16'd0, 16'd0);
    tick();
    drp_xfer("commit2", 7'h7F, 1'b1, 16'd1, 16'd0);
    tick();
    check("commit2_locked_drop", 32'(locked), 32'd0);
    tick();
    for (int j = 0; j <= 20; j++) begin
      if (j != 0) tick();
      check($sformatf("t4_clkout_%0d", j), 32'(clkout), 32'(t4_vec(j)));
      check($sformatf("t4_locked_%0d", j), 32'(locked), 32'(j == 20));
    end
`endif

    // 5. power-down while locked, then release and relock
    pwrdwn = 1'b1;
    tick();
    check("pd_clkout", 32'(clkout), 32'd0);
    check("pd_locked", 32'(locked), 32'd0);
`ifdef DYN_RECONF_EN
    drp_xfer("pd_rd_high2", 7'd9, 1'b0, 16'd0, 16'd9);
    check("pd_clkout_hold", 32'(clkout), 32'd0);
`endif
    pwrdwn = 1'b0;
    tick();
    check("pd_release_clkout", 32'(clkout), 32'd0);
    tick();
    for (int j = 0; j <= LOCK_OFS; j++) begin
      if (j != 0) tick();
      check($sformatf("t5_clkout_%0d", j), 32'(clkout), 32'(run_vec(j)));
      check($sformatf("t5_locked_%0d", j), 32'(locked), 32'(j == LOCK_OFS));
    end

    // 6. asynchronous reset during LOCKING
    pwrdwn = 1'b1;
    tick();
    pwrdwn = 1'b0;
    tick();
    tick();
    for (int j = 1; j <= 4; j++) tick();
    check("t6_pre_clkout", 32'(clkout), 32'(run_vec(4)));
    check("t6_pre_locked", 32'(locked), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clkout", 32'(clkout), 32'd0);
    check("t6_async_locked", 32'(locked), 32'd0);
    check("t6_async_drdy", 32'(drp.drdy), 32'd0);
    check("t6_async_do", 32'(drp.dout), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_defaults_clkout", 32'(clkout), 32'(def_vec(0)));
    tick();
    check("t6_defaults_clkout2", 32'(clkout), 32'(def_vec(1)));
`ifdef DYN_RECONF_EN
    drp_xfer("t6_rd_div0", 7'd0, 1'b0, 16'd0, 16'd2);
    tick();
    drp_xfer("t6_rd_phase0", 7'd2, 1'b0, 16'd0, 16'd0);
    tick();
`else
    drp.daddr = 7'd0;
    drp.dwe   = 1'b1;
    drp.di    = 16'd1;
    drp.den   = 1'b1;
    tick();
    drp.den = 1'b0;
    drp.dwe = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("nodrp_drdy_%0d", j), 32'(drp.drdy), 32'd0);
      check($sformatf("nodrp_do_%0d", j), 32'(drp.dout), 32'd0);
      tick();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
